// File: rtl/mcu_seq_pkg.sv
// mcu_seq_pkg: state type, opcode and branch-select constants shared by the
// MCU sequencer. Defining SEQ_SINGLE_STEP_EN adds the PAUSE state.
package mcu_seq_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        HALT   = 3'd3
`ifdef SEQ_SINGLE_STEP_EN
        ,PAUSE = 3'd4
`endif
    } seq_state_t;

    localparam logic [4:0] OP_IN   = 5'b10100;
    localparam logic [4:0] OP_OUT  = 5'b10101;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [1:0] BS_INC = 2'b00;
    localparam logic [1:0] BS_BRZ = 2'b01;
    localparam logic [1:0] BS_JR  = 2'b10;
    localparam logic [1:0] BS_JMP = 2'b11;

    // Opcodes with no defined meaning: run as NOP and flag illegal.
    function automatic logic is_undefined(input logic [4:0] op);
        return (op == 5'b10000) || ((op >= 5'b10110) && (op <= 5'b11110));
    endfunction

endpackage

// File: rtl/mcu_pc_next.sv
// mcu_pc_next: combinational next-PC selection from the decoder branch select.
// All arithmetic wraps modulo 2^PC_W.
module mcu_pc_next
    import mcu_seq_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [8:0]      offs,
    input  logic [1:0]      bs,
    input  logic            ps,
    input  logic            z_flag,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0]        pc_inc;
    logic signed [PC_W-1:0] off6;
    logic signed [PC_W-1:0] off9;

    assign pc_inc = pc + PC_W'(1);
    // Sign-extend (or, for the 9-bit field at PC_W=8, wrap) the branch offsets.
    assign off6   = PC_W'($signed(offs[5:0]));
    assign off9   = PC_W'($signed(offs[8:0]));

    // Branch-select mux; the conditional branch takes when z_flag differs from PS.
    always_comb begin
        next_pc = pc_inc;
        case (bs)
            BS_INC:  next_pc = pc_inc;
            BS_BRZ:  next_pc = (z_flag ^ ps) ? pc_inc + $unsigned(off6) : pc_inc;
            BS_JR:   next_pc = jr_target;
            default: next_pc = pc_inc + $unsigned(off9);
        endcase
    end

endmodule

// File: rtl/mcu_sequencer.sv
// mcu_sequencer: fetch/decode/execute controller for the MCU datapath.
// Write strobes are the decoder's RW/MW gated to the single completing EXEC
// cycle; IN/OUT opcodes hold EXEC until the FPGA handshake completes.
// Optional feature macro: SEQ_SINGLE_STEP_EN (pause after each instruction
// until a step pulse). Without it the step input is ignored.
module mcu_sequencer
    import mcu_seq_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir,
    input  logic               dec_rw,
    input  logic               dec_mw,
    input  logic [1:0]         dec_bs,
    input  logic               dec_ps,
    input  logic               z_flag,
    input  logic [PC_W-1:0]    jr_target,
    output logic               rf_we,
    output logic               dm_we,
    input  logic               io_in_valid,
    output logic               io_in_ack,
    output logic               io_out_valid,
    input  logic               io_out_ready,
    output logic               illegal,
    output logic               halted,
    input  logic               step
);

    seq_state_t         state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_nxt;
    logic [INSTR_W-1:0] ir_q;
    logic [4:0]         opcode;
    logic               exec_done;

`ifndef SEQ_SINGLE_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    assign imem_addr = pc;
    assign ir        = ir_q;
    assign opcode    = ir_q[16:12];
    assign pc_inc    = pc + PC_W'(1);

    mcu_pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc        (pc),
        .offs      (ir_q[8:0]),
        .bs        (dec_bs),
        .ps        (dec_ps),
        .z_flag    (z_flag),
        .jr_target (jr_target),
        .next_pc   (pc_nxt)
    );

    // EXEC-only strobes and the completion condition for the current opcode.
    always_comb begin
        rf_we     = 1'b0;
        dm_we     = 1'b0;
        io_in_ack = 1'b0;
        illegal   = 1'b0;
        exec_done = 1'b1;
        if (state == EXEC) begin
            if (opcode == OP_IN) begin
                rf_we     = io_in_valid;
                io_in_ack = io_in_valid;
                exec_done = io_in_valid;
            end else if (opcode == OP_OUT) begin
                exec_done = io_out_ready;
            end else if (opcode != OP_HALT) begin
                if (is_undefined(opcode)) begin
                    illegal = 1'b1;
                end else begin
                    rf_we = dec_rw;
                    dm_we = dec_mw;
                end
            end
        end
    end

    // Sequencer FSM with PC, IR and the registered io_out_valid/halted flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= '0;
            ir_q         <= '0;
            io_out_valid <= 1'b0;
            halted       <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    ir_q         <= imem_data;
                    io_out_valid <= (imem_data[16:12] == OP_OUT);
                    state        <= EXEC;
                end
                EXEC: begin
                    if (opcode == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (exec_done) begin
                        pc           <= is_undefined(opcode) ? pc_inc : pc_nxt;
                        io_out_valid <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
                        state        <= PAUSE;
`else
                        state        <= FETCH;
`endif
                    end
                end
                HALT: state <= HALT;
`ifdef SEQ_SINGLE_STEP_EN
                PAUSE: begin
                    if (step) state <= FETCH;
                end
`endif
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: directed table, hand-written corner sequences and a
// randomized program run against an instruction-level reference model.
module tb_mcu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  imem_addr;
    logic [16:0] imem_data;
    logic [16:0] ir;
    logic        dec_rw, dec_mw, dec_ps;
    logic [1:0]  dec_bs;
    logic        z_flag = 1'b0;
    logic [7:0]  jr_target = 8'h00;
    logic        rf_we, dm_we;
    logic        io_in_valid = 1'b0, io_in_ack, io_out_valid, io_out_ready = 1'b0;
    logic        illegal, halted;
    logic        step = 1'b0;

    logic [16:0] mem [256];
    logic [7:0]  mpc;
    bit          auto_step = 1'b1;
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [4:0] T_IN   = 5'b10100;
    localparam logic [4:0] T_OUT  = 5'b10101;
    localparam logic [4:0] T_HALT = 5'b11111;

    mcu_sequencer #(.PC_W(8), .INSTR_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .ir(ir), .dec_rw(dec_rw), .dec_mw(dec_mw), .dec_bs(dec_bs), .dec_ps(dec_ps),
        .z_flag(z_flag), .jr_target(jr_target), .rf_we(rf_we), .dm_we(dm_we),
        .io_in_valid(io_in_valid), .io_in_ack(io_in_ack), .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready), .illegal(illegal), .halted(halted), .step(step)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory.
    always @(posedge clk) imem_data <= mem[imem_addr];

    function automatic bit undef_op(input logic [4:0] op);
        return (op == 5'b10000) || (op >= 5'b10110 && op <= 5'b11110);
    endfunction

    // Toy decoder: returns {rw, mw, bs[1:0], ps}.
    function automatic logic [4:0] dec_of(input logic [4:0] op);
        case (op)
            5'b00001: return 5'b10_00_0;  // ADD
            5'b00010: return 5'b01_00_0;  // ST
            5'b01110: return 5'b00_10_0;  // JR
            5'b10001: return 5'b00_11_0;  // JMP
            5'b10010: return 5'b00_01_0;  // BRZ
            5'b10011: return 5'b00_01_1;  // BNZ
            5'b10100: return 5'b10_00_0;  // IN
            5'b10101: return 5'b10_00_0;  // OUT (RW must be ignored)
            default:  return (undef_op(op) || op == T_HALT) ? 5'b11_00_0 : 5'b00_00_0;
        endcase
    endfunction

    always_comb {dec_rw, dec_mw, dec_bs, dec_ps} = dec_of(ir[16:12]);

    // Instruction-level next-PC rule.
    function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [16:0] ins,
                                              input logic z, input logic [7:0] jr);
        logic [4:0] d;
        int off;
        int t;
        d = dec_of(ins[16:12]);
        t = int'(pc) + 1;
        if (!undef_op(ins[16:12])) begin
            if (d[2:1] == 2'd1 && (z ^ d[0])) begin
                off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
                t = t + off;
            end else if (d[2:1] == 2'd2) begin
                t = int'(jr);
            end else if (d[2:1] == 2'd3) begin
                off = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
                t = t + off;
            end
        end
        return t[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        io_in_valid = 1'b0; io_out_ready = 1'b0; step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_addr", imem_addr, 0);
        chk("rst_ir", ir, 0);
        chk("rst_strobes", {rf_we, dm_we, io_in_ack}, 0);
        chk("rst_flags", {io_out_valid, illegal, halted}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mpc = 8'h00;
    endtask

    // Runs one instruction from its FETCH cycle; called at a negedge in FETCH.
    task automatic do_instr(input logic z, input logic [7:0] jr, input int wt,
                            output int n_rw, output int n_mw, output int n_ill, output int elen);
        logic [16:0] ins;
        logic [4:0]  op, d;
        logic        last, e_rw, e_mw, e_ill;
        ins = mem[mpc];
        op = ins[16:12];
        d = dec_of(op);
        n_rw = 0; n_mw = 0; n_ill = 0; elen = 0;
        if (op != T_IN && op != T_OUT) wt = 0;
        z_flag = z; jr_target = jr; io_in_valid = 1'b0; io_out_ready = 1'b0;
        #1;
        chk("fetch_addr", imem_addr, mpc);
        chk("fetch_strobes", {rf_we, dm_we}, 0);
        @(negedge clk);
        #1;
        chk("decode_addr", imem_addr, mpc);
        chk("decode_strobes", {rf_we, dm_we}, 0);
        @(negedge clk);
        if (op == T_HALT) begin
            #1;
            chk("halt_exec_strobes", {rf_we, dm_we, illegal}, 0);
            elen = 1;
            @(negedge clk);
            #1;
            chk("halted", halted, 1);
            chk("halt_addr", imem_addr, mpc);
            return;
        end
        for (int k = 0; k <= wt; k++) begin
            last = (k == wt);
            io_in_valid = (op == T_IN) && last;
            io_out_ready = (op == T_OUT) && last;
            #1;
            if (op == T_IN) begin
                e_rw = last; e_mw = 1'b0; e_ill = 1'b0;
            end else if (op == T_OUT) begin
                e_rw = 1'b0; e_mw = 1'b0; e_ill = 1'b0;
            end else if (undef_op(op)) begin
                e_rw = 1'b0; e_mw = 1'b0; e_ill = 1'b1;
            end else begin
                e_rw = d[4]; e_mw = d[3]; e_ill = 1'b0;
            end
            chk("exec_ir", ir, ins);
            chk("exec_rf_we", rf_we, e_rw);
            chk("exec_dm_we", dm_we, e_mw);
            chk("exec_illegal", illegal, e_ill);
            chk("exec_in_ack", io_in_ack, (op == T_IN) && last);
            chk("exec_out_valid", io_out_valid, op == T_OUT);
            n_rw += int'(rf_we); n_mw += int'(dm_we); n_ill += int'(illegal);
            elen++;
            @(negedge clk);
        end
        io_in_valid = 1'b0; io_out_ready = 1'b0;
        mpc = model_next(mpc, ins, z, jr);
`ifdef SEQ_SINGLE_STEP_EN
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("pause_strobes", {rf_we, dm_we}, 0);
            chk("pause_addr", imem_addr, mpc);
            @(negedge clk);
        end
        if (auto_step) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
`endif
    endtask

    typedef struct {
        logic [7:0]  pc;
        logic [16:0] ins;
        logic        z;
        int          wt;
        logic [7:0]  jr;
        logic [7:0]  exp_pc;
        int          exp_rw, exp_mw, exp_ill, exp_len;
    } vec_t;

    vec_t tbl [16];
    logic [4:0] ops [12];

    initial begin
        int a, b, c, e;
        int n_rw, n_mw, n_ill, elen, cnt;
        logic [31:0] mask;

        tbl[0]  = '{8'h05, {5'b10010, 12'h03E}, 1'b1, 0, 8'h00, 8'h04, 0, 0, 0, 1};
        tbl[1]  = '{8'h05, {5'b10010, 12'h03E}, 1'b0, 0, 8'h00, 8'h06, 0, 0, 0, 1};
        tbl[2]  = '{8'h05, {5'b10011, 12'h03E}, 1'b1, 0, 8'h00, 8'h06, 0, 0, 0, 1};
        tbl[3]  = '{8'h05, {5'b10011, 12'h03E}, 1'b0, 0, 8'h00, 8'h04, 0, 0, 0, 1};
        tbl[4]  = '{8'hFF, {5'b10010, 12'h03F}, 1'b1, 0, 8'h00, 8'hFF, 0, 0, 0, 1};
        tbl[5]  = '{8'hFF, {5'b00001, 12'h000}, 1'b0, 0, 8'h00, 8'h00, 1, 0, 0, 1};
        tbl[6]  = '{8'h20, {5'b10001, 12'h1F0}, 1'b0, 0, 8'h00, 8'h11, 0, 0, 0, 1};
        tbl[7]  = '{8'h10, {5'b01110, 12'h000}, 1'b0, 0, 8'hA0, 8'hA0, 0, 0, 0, 1};
        tbl[8]  = '{8'h30, {5'b00010, 12'h000}, 1'b0, 0, 8'h00, 8'h31, 0, 1, 0, 1};
        tbl[9]  = '{8'h40, {5'b10110, 12'h000}, 1'b0, 0, 8'h00, 8'h41, 0, 0, 1, 1};
        tbl[10] = '{8'h41, {5'b10000, 12'h000}, 1'b0, 0, 8'h00, 8'h42, 0, 0, 1, 1};
        tbl[11] = '{8'h50, {5'b10101, 12'h000}, 1'b0, 0, 8'h00, 8'h51, 0, 0, 0, 1};
        tbl[12] = '{8'h02, {5'b10100, 12'h000}, 1'b0, 4, 8'h00, 8'h03, 1, 0, 0, 5};
        tbl[13] = '{8'h61, {5'b10101, 12'h000}, 1'b0, 2, 8'h00, 8'h62, 0, 0, 0, 3};
        tbl[14] = '{8'h60, {5'b10100, 12'h000}, 1'b0, 0, 8'h00, 8'h61, 1, 0, 0, 1};
        tbl[15] = '{8'h07, {5'b11110, 12'h000}, 1'b0, 0, 8'h00, 8'h08, 0, 0, 1, 1};
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b01110, 5'b10001, 5'b10010,
                5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10000, 5'b11000};
        for (int i = 0; i < 256; i++) mem[i] = 17'h0;

        // Directed table: a JR at address 0 lands on the instruction under test.
        for (int i = 0; i < 16; i++) begin
            mem[0] = {5'b01110, 12'h000};
            mem[tbl[i].pc] = tbl[i].ins;
            do_reset();
            do_instr(1'b0, tbl[i].pc, 0, a, b, c, e);
            do_instr(tbl[i].z, tbl[i].jr, tbl[i].wt, n_rw, n_mw, n_ill, elen);
            #1;
            chk($sformatf("tbl%0d_pc", i), imem_addr, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_rw", i), n_rw, tbl[i].exp_rw);
            chk($sformatf("tbl%0d_mw", i), n_mw, tbl[i].exp_mw);
            chk($sformatf("tbl%0d_ill", i), n_ill, tbl[i].exp_ill);
            chk($sformatf("tbl%0d_len", i), elen, tbl[i].exp_len);
        end

`ifndef SEQ_SINGLE_STEP_EN
        // Three ADDs: rf_we at cycles 3, 6, 9; fetch addresses 0..3.
        for (int i = 0; i < 256; i++) mem[i] = 17'h0;
        for (int i = 0; i < 3; i++) mem[i] = {5'b00001, 12'h000};
        do_reset();
        mask = 0;
        for (int cy = 1; cy <= 10; cy++) begin
            #1;
            if (rf_we) mask = mask | (32'd1 << cy);
            if (cy % 3 == 1) chk("add_fetch_addr", imem_addr, (cy - 1) / 3);
            @(negedge clk);
        end
        chk("add_rf_we_cycles", mask, 32'h248);
`endif

        // Reset asserted during EXEC of a store.
        mem[0] = {5'b00010, 12'h000};
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("st_dm_we_exec", dm_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("st_abort_dm_we", dm_we, 0);
        chk("st_abort_pc", imem_addr, 0);
        chk("st_abort_ir", ir, 0);
        @(negedge clk);
        #1;
        chk("st_abort_dm_we_next", dm_we, 0);

        // HALT freezes the address and stays halted.
        mem[0] = {5'b01110, 12'h000};
        mem[8'h33] = {5'b11111, 12'h000};
        do_reset();
        do_instr(1'b0, 8'h33, 0, a, b, c, e);
        do_instr(1'b0, 8'h00, 0, a, b, c, e);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("halt_frozen_addr", imem_addr, 8'h33);
            chk("halt_hold", {halted, rf_we, dm_we}, 3'b100);
        end

`ifdef SEQ_SINGLE_STEP_EN
        // First instruction runs freely, one step pulse runs exactly one more.
        for (int i = 0; i < 4; i++) mem[i] = {5'b00001, 12'h000};
        do_reset();
        auto_step = 1'b1;
        do_instr(1'b0, 8'h00, 0, a, b, c, e);
        auto_step = 1'b0;
        do_instr(1'b0, 8'h00, 0, n_rw, b, c, e);
        chk("step_second_rw", n_rw, 1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            cnt += int'(rf_we);
            chk("step_hold_addr", imem_addr, 8'h02);
            @(negedge clk);
        end
        chk("step_extra_rf_we", cnt, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        auto_step = 1'b1;
`endif

        // Randomized program against the instruction-level model.
        for (int i = 0; i < 256; i++) mem[i] = {ops[$urandom_range(0, 11)], 12'($urandom)};
        do_reset();
        for (int i = 0; i < 300; i++) begin
            do_instr(1'($urandom), 8'($urandom), $urandom_range(0, 3), a, b, c, e);
        end
        #1;
        chk("rand_final_pc", imem_addr, mpc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mcu_sequencer.md
# mcu_sequencer

Multi-cycle fetch/decode/execute controller for the MCU datapath. Fetches 17-bit instructions from synchronous instruction memory into an instruction register feeding the combinational instruction decoder. Gates the decoder's register-file and data-memory write strobes to a single execute cycle, and computes the next PC from the decoder's branch select. Stalls on the FPGA input/output handshakes.

## Interface
Parameters:
- PC_W, 8, program-counter and instruction-address width (8..16)
- INSTR_W, 17, instruction width; fixed at 17, opcode in [16:12]

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  PC_W  instruction address (= PC)
- imem_data  in  INSTR_W  instruction read data, valid one cycle after imem_addr
- ir  out  INSTR_W  instruction register, drives decoder instruct input
- dec_rw  in  1  decoder RW
- dec_mw  in  1  decoder MW
- dec_bs  in  2  decoder BS
- dec_ps  in  1  decoder PS
- z_flag  in  1  ALU zero flag of current execute cycle
- jr_target  in  PC_W  register B read data, used for jump-register
- rf_we  out  1  gated register-file write enable
- dm_we  out  1  gated data-memory write enable
- io_in_valid  in  1  FPGA input data available
- io_in_ack  out  1  input consumed (one-cycle pulse)
- io_out_valid  out  1  output data on bus
- io_out_ready  in  1  FPGA accepts output
- illegal  out  1  one-cycle pulse on undefined opcode
- halted  out  1  sequencer stopped
- step  in  1  single-step pulse (only with SEQ_SINGLE_STEP_EN; otherwise ignored)

## Operation
- States: FETCH, DECODE, EXEC, HALT (plus PAUSE under macro).
- FETCH: imem_addr = PC → DECODE.
- DECODE: IR <= imem_data → EXEC.
- EXEC, normal opcodes: rf_we = dec_rw, dm_we = dec_mw for exactly one cycle; PC <= next_pc; → FETCH.
- next_pc, all arithmetic modulo 2^PC_W:
  - BS=00: PC+1.
  - BS=01: PC+1+sext(ir[5:0]) if (z_flag XOR dec_ps), else PC+1.
  - BS=10: jr_target.
  - BS=11: PC+1+sext(ir[8:0]).
- Opcode 10100 (input): stay in EXEC with rf_we=0 while io_in_valid=0. In the cycle io_in_valid=1: rf_we=1, io_in_ack=1, PC advances.
- Opcode 10101 (output): io_out_valid=1 throughout EXEC. Complete in the cycle io_out_ready=1. rf_we forced 0 (the decoder's RW for this opcode is ignored).
- Opcode 11111: → HALT. PC is not advanced. halted=1 until reset.
- Opcodes 10000 and 10110–11110: executed as NOP (no strobes), illegal=1 for one EXEC cycle, PC+1.
- Strobes are never asserted outside EXEC, regardless of decoder outputs.

## Timing
- Reset values: state FETCH, PC=0, IR=0 (NOP), rf_we=dm_we=io_in_ack=io_out_valid=illegal=halted=0.
- 3 cycles per instruction, plus IO wait cycles.
- Reset asserted mid-instruction aborts immediately. No strobe appears in the cycle after rst_n falls. The first fetch is in the first clock edge after rst_n rises.
- If io_in_valid/io_out_ready is already high on EXEC entry, the instruction completes with no extra cycle.
- Branch offsets wrap: PC=0xFF, offset −1 → PC+1+(−1)=0xFF; PC=0xFF, BS=00 → 0x00.

## Configuration
- SEQ_SINGLE_STEP_EN defined: EXEC completion → PAUSE instead of FETCH. PAUSE → FETCH on step=1; outputs as in FETCH minus address change. Reset enters FETCH (first instruction runs freely).
- Undefined: no PAUSE state, step port present but unused.

## Structure
- Package mcu_seq_pkg:
  - state enum.
  - opcode constants OP_IN=5'b10100, OP_OUT=5'b10101, OP_HALT=5'b11111.
  - BS encodings BS_INC/BS_BRZ/BS_JR/BS_JMP.
- Sub-module mcu_pc_next: combinational next-PC from PC, ir, dec_bs, dec_ps, z_flag, jr_target.

## Test plan
- Reset, program of three ADDs (opcode 00001) → rf_we pulses at cycles 3, 6, 9 after reset release; imem_addr 0,1,2,3.
- BRZ (10010, ir[5:0]=6'h3E) at PC=5, z_flag=1 → PC=4. Same with z_flag=0 → PC=6. BNZ (PS=1) inverts both.
- Input at PC=2, io_in_valid held low 4 cycles then high → EXEC lasts 5 cycles; single rf_we+io_in_ack pulse; PC=3.
- Output with io_out_ready high on entry → io_out_valid 1 cycle, rf_we=0. Opcode 10110 → illegal pulse, no strobes. Opcode 11111 → halted=1, imem_addr frozen.
- rst_n dropped during EXEC of a store → dm_we=0 from that point, PC=0, IR=0. Jump-register with jr_target=0xA0 → next fetch at 0xA0.
- With SEQ_SINGLE_STEP_EN: two instructions, step pulsed once → exactly one additional instruction executes.
